display_driver_bcm: RTL and testbench
=====================================

# display_driver_bcm

Parametrised successor panel driver for serial row/column latched LED matrices (HUB75-style). It scans `rows` addressed rows across `segments` parallel RGB lanes using binary-coded modulation (BCM): one shift/latch per bit plane, with on-time weighted 2^plane. Bit-plane shifting is pipelined under the previous plane's display time. It sits between the frame-buffer BRAM (fetch address out, pixel in) and the panel pins, and exposes a frame-flip handshake.

## Interface
- `segments`, 2: parallel RGB lanes, each driving one panel half.
- `rows`, 16: addressable rows per segment.
- `columns`, 64: pixels shifted per row.
- `bitdepth`, 8: bits per colour channel, which is also the number of bit planes.
- `lsb_time`, 4: clocks of OE for plane 0. Must be ≥1.
- `blank_time`, 2: OE-low clocks before each latch. Must be ≥1.
- `pipe_latency`, 3: clocks from address change to valid `pixel`.
- `clk`  in  1  clock; all logic on posedge.
- `rst`  in  1  reset; synchronous, active-high.
- `pixel`  in  3*bitdepth*segments  fetched data. Bit (s*3+c)*bitdepth+b = segment s, channel c (0=R, 1=G, 2=B), bit b.
- `flip_req`  in  1  producer requests buffer swap; held until `flip_ack`.
- `row`  out  clog2(rows)  fetch row address.
- `column`  out  clog2(columns)  fetch column address.
- `row_sel`  out  clog2(rows)  panel row select.
- `rgb`  out  3*segments  serial data; bit s*3+c.
- `oclk`, `lat`, `oe`  out  1 each  panel shift clock, latch, output enable (active-high).
- `flip_ack`  out  1  one-cycle pulse; swap buffers now.

## Operation
- Reset: every output is 0. Shift FSM goes to FILL; plane=0; display timer=0.
- Shift FSM:
  - FILL: hold for pipe_latency clocks after column is set to 0 → SHIFT_L.
  - SHIFT_L: oclk=0; rgb = pixel bit `plane` per lane; column advances → SHIFT_H.
  - SHIFT_H: oclk=1 → SHIFT_L, or → WAIT after columns highs have been issued.
  - WAIT: idle until display timer==0 → BLANK.
  - BLANK: oe=0 for blank_time clocks → LATCH.
  - LATCH: lat=1 for one clock; row_sel ← row of the latched plane; display timer ← lsb_time<<plane; plane/row advance; → FILL.
- The shift FSM keeps column advancing at one address per SHIFT_L, so data stays pipe_latency ahead.
- oe=1 exactly while display timer>0 and the FSM is not in BLANK or LATCH. The timer decrements each clock while oe=1.
- Advance order: plane 0..bitdepth-1, then row+1; after rows-1 the row wraps to 0.
- Frame boundary is the LATCH of row rows-1, plane bitdepth-1. If flip_req=1 in that cycle, flip_ack=1 the next cycle. Otherwise no ack, and the request waits for the next frame.
- Timer width is clog2(lsb_time<<(bitdepth-1))+1 bits. Shifts never truncate.
- Reset mid-shift or mid-display forces oe=0 and lat=0 on the next clock and restarts at row 0, plane 0. No partial latch is issued.

## Timing
- Plane shift cost: pipe_latency + 2*columns clocks.
- Display starts the clock after LATCH.
- Planes with lsb_time<<plane < shift cost show an idle oe=0 gap. Longer planes stall the shifter in WAIT.
- lat never rises while oe=1.
- row_sel changes only in the LATCH cycle, which always has oe=0 and follows ≥blank_time oe=0 clocks.
- oclk period is 2 clocks. rgb changes only on the SHIFT_L cycle (oclk low).

## Configuration
- `DISPLAY_DRIVER_BRIGHTNESS_EN` defined:
  - Adds input `brightness` [7:0], sampled at LATCH.
  - Timer load is ((lsb_time<<plane)*brightness)>>8.
  - A result of 0 skips display, so oe stays 0 for that plane.
- Undefined: the port is absent and the full weight is used.

## Test plan
- Reset: hold rst 3 clocks mid-display → all outputs 0 the next clock; first lat comes after pipe_latency+2*columns+blank_time+1 clocks.
- Shift count (columns=8, segments=1, pixel R=0xA5 constant): exactly 8 oclk rises per lat; rgb[0] equals bit `plane` of 0xA5 (1,0,1,0,0,1,0,1).
- BCM weights (lsb_time=4, bitdepth=4, columns=4): oe high runs measure 4, 8, 16, 32 clocks for planes 0..3.
- Row select (rows=4): row_sel steps 0→1→2→3→0 every bitdepth latches; oe=0 for ≥blank_time clocks before each change; no lat while oe=1.
- Flip: raise flip_req mid-frame → single flip_ack pulse the clock after the last-row/last-plane LATCH. flip_req low at the boundary → no ack.
- Brightness (macro on, lsb_time=4, brightness=0x80 then 0x00): plane-3 oe run is 16 clocks; with 0x00, oe stays 0 for the whole frame.

Source files
------------

// File: rtl/display_driver_bcm.sv
// display_driver_bcm: HUB75-style LED matrix scan driver using binary-coded modulation, with each plane shifted under the previous plane's display time.
// Latency: first lat comes pipe_latency+2*columns+blank_time+1 clocks after reset; each plane's display starts the clock after its latch.
// Backpressure: the panel side has none; flip_req is held by the producer and acknowledged only at a frame boundary.
// Optional feature: define DISPLAY_DRIVER_BRIGHTNESS_EN to add an 8-bit global brightness input that scales every plane's on-time.
module display_driver_bcm #(
    parameter int segments     = 2,
    parameter int rows         = 16,
    parameter int columns      = 64,
    parameter int bitdepth     = 8,
    parameter int lsb_time     = 4,
    parameter int blank_time   = 2,
    parameter int pipe_latency = 3
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [3*bitdepth*segments-1:0]     pixel,
    input  logic                               flip_req,
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    input  logic [7:0]                         brightness,
`endif
    output logic [$clog2(rows)-1:0]            row,
    output logic [$clog2(columns)-1:0]         column,
    output logic [$clog2(rows)-1:0]            row_sel,
    output logic [3*segments-1:0]              rgb,
    output logic                               oclk,
    output logic                               lat,
    output logic                               oe,
    output logic                               flip_ack
);
    localparam int LANES = 3 * segments;
    localparam int RW    = $clog2(rows);
    localparam int CW    = $clog2(columns);
    localparam int PW    = (bitdepth > 1) ? $clog2(bitdepth) : 1;
    localparam int TW    = $clog2(lsb_time << (bitdepth - 1)) + 1;
    localparam int DMAX  = (pipe_latency > blank_time) ? pipe_latency : blank_time;
    localparam int DW    = $clog2(DMAX + 1);
    localparam int HW    = $clog2(columns + 1);

    localparam logic [DW-1:0] FILL_LAST  = DW'((pipe_latency > 0) ? pipe_latency - 1 : 0);
    localparam logic [DW-1:0] BLANK_LAST = DW'(blank_time - 1);
    localparam logic [HW-1:0] HI_LAST    = HW'(columns - 1);
    localparam logic [CW-1:0] COL_LAST   = CW'(columns - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(rows - 1);
    localparam logic [PW-1:0] PLANE_LAST = PW'(bitdepth - 1);

    typedef enum logic [2:0] {
        ST_FILL, ST_SHIFT_L, ST_SHIFT_H, ST_WAIT, ST_BLANK, ST_LATCH
    } state_t;

    state_t             state_q, state_nxt;
    logic [DW-1:0]      dly_cnt;
    logic [HW-1:0]      hi_cnt;
    logic [PW-1:0]      plane;
    logic [TW-1:0]      timer;
    logic [TW-1:0]      weight;
    logic [TW-1:0]      timer_load;
    logic [LANES-1:0]   lane_bits;
    logic [LANES-1:0]   rgb_q;
    logic               frame_end;

    // Pick bit `plane` of every lane's channel word.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [bitdepth-1:0] ch;
        assign ch           = pixel[k*bitdepth +: bitdepth];
        assign lane_bits[k] = ch[plane];
    end

    // Plane on-time; the timer is wide enough that the top plane never truncates.
    assign weight = TW'(lsb_time) << plane;
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    logic [TW+7:0] scaled;
    assign scaled     = {8'd0, weight} * {{TW{1'b0}}, brightness};
    assign timer_load = scaled[TW+7:8];
`else
    assign timer_load = weight;
`endif

    assign frame_end = (row == ROW_LAST) && (plane == PLANE_LAST);

    // Next state and panel pin decode from the registered state and timer.
    always_comb begin
        state_nxt = state_q;
        oclk      = (state_q == ST_SHIFT_H);
        lat       = (state_q == ST_LATCH);
        oe        = (timer != '0) && (state_q != ST_BLANK) && (state_q != ST_LATCH);
        rgb       = (state_q == ST_SHIFT_L) ? lane_bits : rgb_q;
        case (state_q)
            ST_FILL:    if (dly_cnt == FILL_LAST) state_nxt = ST_SHIFT_L;
            ST_SHIFT_L: state_nxt = ST_SHIFT_H;
            ST_SHIFT_H: state_nxt = (hi_cnt == HI_LAST) ? ST_WAIT : ST_SHIFT_L;
            ST_WAIT:    if (timer == '0) state_nxt = ST_BLANK;
            ST_BLANK:   if (dly_cnt == BLANK_LAST) state_nxt = ST_LATCH;
            ST_LATCH:   state_nxt = ST_FILL;
            default:    state_nxt = ST_FILL;
        endcase
    end

    // State register, shift/scan counters, display timer and fetch addresses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_FILL;
            dly_cnt  <= '0;
            hi_cnt   <= '0;
            plane    <= '0;
            timer    <= '0;
            rgb_q    <= '0;
            row      <= '0;
            column   <= '0;
            row_sel  <= '0;
            flip_ack <= 1'b0;
        end else begin
            state_q  <= state_nxt;
            flip_ack <= (state_q == ST_LATCH) && frame_end && flip_req;

            // FILL and BLANK durations count from each fresh entry.
            if (state_nxt != state_q)
                dly_cnt <= '0;
            else if (state_q == ST_FILL || state_q == ST_BLANK)
                dly_cnt <= dly_cnt + 1'b1;

            // Timer reloads at the latch and runs down while the panel is lit.
            if (state_q == ST_LATCH)
                timer <= timer_load;
            else if (oe)
                timer <= timer - 1'b1;

            // Row select moves on the clock that lat goes high, never while lit.
            if (state_q == ST_BLANK && state_nxt == ST_LATCH)
                row_sel <= row;

            case (state_q)
                ST_SHIFT_L: begin
                    rgb_q  <= lane_bits;
                    column <= (column == COL_LAST) ? '0 : column + 1'b1;
                end
                ST_SHIFT_H: begin
                    hi_cnt <= (hi_cnt == HI_LAST) ? '0 : hi_cnt + 1'b1;
                end
                ST_LATCH: begin
                    column <= '0;
                    if (plane == PLANE_LAST) begin
                        plane <= '0;
                        row   <= (row == ROW_LAST) ? '0 : row + 1'b1;
                    end else begin
                        plane <= plane + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_display_driver_bcm.sv
// Bench for display_driver_bcm: a pin-level panel monitor records every latch,
// then per-latch records are compared against a table and an arithmetic model.
`timescale 1ns/1ps
module tb_display_driver_bcm;
    localparam int SEG   = 2;
    localparam int ROWS  = 4;
    localparam int COLS  = 8;
    localparam int BD    = 4;
    localparam int LSB   = 4;
    localparam int BT    = 2;
    localparam int PL    = 3;
    localparam int PIXW  = 3 * BD * SEG;
    localparam int LANES = 3 * SEG;
    localparam int NL    = 48;
    localparam int NT    = 8;

    typedef struct {
        logic [PIXW-1:0]  pix;
        logic [LANES-1:0] rgb;
        int               run;
        int               rsel;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [PIXW-1:0]   pixel = '0;
    logic              flip_req = 1'b0;
    logic [1:0]        row, row_sel;
    logic [2:0]        column;
    logic [LANES-1:0]  rgb;
    logic              oclk, lat, oe, flip_ack;
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
    logic [7:0]        brightness = 8'h80;
`endif

    always #5 clk = ~clk;

    display_driver_bcm #(
        .segments(SEG), .rows(ROWS), .columns(COLS), .bitdepth(BD),
        .lsb_time(LSB), .blank_time(BT), .pipe_latency(PL)
    ) dut (
        .clk(clk), .rst(rst), .pixel(pixel), .flip_req(flip_req),
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
        .brightness(brightness),
`endif
        .row(row), .column(column), .row_sel(row_sel), .rgb(rgb),
        .oclk(oclk), .lat(lat), .oe(oe), .flip_ack(flip_ack)
    );

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input longint actual, input longint expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Reference model: lane k shows bit `plane` of its channel word.
    function automatic logic [LANES-1:0] model_rgb(input logic [PIXW-1:0] p, input int plane);
        logic [LANES-1:0] r;
        logic [PIXW-1:0]  t;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            t    = p >> (k * BD + plane);
            r[k] = t[0];
        end
        return r;
    endfunction

    function automatic int scale(input int w);
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
        return (w * 128) >> 8;
`else
        return w;
`endif
    endfunction

    // Panel monitor state
    bit               mon_en = 1'b0;
    int               n_lat = 0, oclk_cnt = 0, run_cnt = 0, low_cnt = 0;
    logic             prev_oclk = 1'b0, prev_oe = 1'b0, prev_lat = 1'b0;
    logic [1:0]       prev_row_sel = '0;
    logic [LANES-1:0] prev_rgb = '0, first_rgb = '0;
    bit               rgb_ok = 1'b1;
    int               lat_oclk[64], lat_rowsel[64], lat_low[64], run_len[64];
    logic [LANES-1:0] lat_rgb[64];
    bit               lat_rgbok[64];
    logic [PIXW-1:0]  pix_hist[64];
    int               ack_cnt = 0, ack_nlat = -1;
    bit               ack_after_lat = 1'b0;
    int               viol_lat_oe = 0, viol_rowsel = 0, viol_rgb = 0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (oclk && !prev_oclk) begin
                if (oclk_cnt == 0) first_rgb = rgb;
                else if (rgb != first_rgb) rgb_ok = 1'b0;
                oclk_cnt++;
            end
            if (oclk && rgb != prev_rgb) viol_rgb++;
            if (lat && oe) viol_lat_oe++;
            if (row_sel != prev_row_sel && !lat) viol_rowsel++;
            if (oe) run_cnt++;
            else if (prev_oe) begin
                if (n_lat > 0 && n_lat <= 64) run_len[n_lat-1] = run_cnt;
                run_cnt = 0;
            end
            if (lat && n_lat < 64) begin
                lat_oclk[n_lat]   = oclk_cnt;
                lat_rgb[n_lat]    = first_rgb;
                lat_rgbok[n_lat]  = rgb_ok;
                lat_rowsel[n_lat] = row_sel;
                lat_low[n_lat]    = low_cnt;
                run_len[n_lat]    = 0;
                n_lat++;
                oclk_cnt = 0;
                rgb_ok   = 1'b1;
            end
            if (flip_ack) begin
                ack_cnt++;
                ack_nlat      = n_lat;
                ack_after_lat = prev_lat;
            end
            low_cnt = oe ? 0 : low_cnt + 1;
        end
        prev_oclk    = oclk;
        prev_oe      = oe;
        prev_lat     = lat;
        prev_row_sel = row_sel;
        prev_rgb     = rgb;
    end

    // Flip producer: request mid-frame 0, drop on the acknowledge.
    initial begin
        int w;
        w = 0;
        while (n_lat < 5 && w < 3000) begin @(negedge clk); w++; end
        flip_req = 1'b1;
        w = 0;
        while (!flip_ack && w < 3000) begin @(negedge clk); w++; end
        flip_req = 1'b0;
    end

    vec_t tbl[NT];

    initial begin
        int k, lat_seen, oe_seen;
        logic [LANES-1:0] er;
        int erun, ersel, pl;

        tbl[0] = '{24'hA5C30F, 6'h15, 4,  0};
        tbl[1] = '{24'hA5C30F, 6'h25, 8,  0};
        tbl[2] = '{24'hA5C30F, 6'h19, 16, 0};
        tbl[3] = '{24'hA5C30F, 6'h29, 32, 0};
        tbl[4] = '{24'hFFF000, 6'h38, 4,  1};
        tbl[5] = '{24'hFFF000, 6'h38, 8,  1};
        tbl[6] = '{24'h000FFF, 6'h07, 16, 1};
        tbl[7] = '{24'h000FFF, 6'h07, 32, 1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_oe", oe, 0);
        check("rst_lat", lat, 0);
        check("rst_oclk", oclk, 0);
        check("rst_rgb", rgb, 0);
        check("rst_row_sel", row_sel, 0);
        check("rst_flip_ack", flip_ack, 0);
        check("rst_row", row, 0);
        check("rst_column", column, 0);

        // Main run: table vectors first, then random pixel words
        pixel  = tbl[0].pix;
        mon_en = 1'b1;
        rst    = 1'b0;
        for (int n = 0; n <= NL; n++) begin
            int waited;
            if (n < NT) pixel = tbl[n].pix;
            else        pixel = PIXW'($urandom);
            pix_hist[n] = pixel;
            waited = 0;
            while (n_lat <= n && waited < 400) begin @(negedge clk); waited++; end
            if (n_lat <= n) begin
                check("lat_timeout", n_lat, n + 1);
                break;
            end
        end
        mon_en = 1'b0;

        for (int n = 0; n < NL; n++) begin
            pl = n % BD;
            if (n < NT) begin
                er = tbl[n].rgb; erun = tbl[n].run; ersel = tbl[n].rsel;
            end else begin
                er = model_rgb(pix_hist[n], pl); erun = LSB << pl; ersel = (n / BD) % ROWS;
            end
            erun = scale(erun);
            check($sformatf("oclk_per_lat[%0d]", n), lat_oclk[n], COLS);
            check($sformatf("rgb[%0d]", n), lat_rgb[n], er);
            check($sformatf("rgb_stable[%0d]", n), lat_rgbok[n], 1);
            check($sformatf("row_sel[%0d]", n), lat_rowsel[n], ersel);
            check($sformatf("blank_before_lat[%0d]", n), lat_low[n] >= BT, 1);
            check($sformatf("oe_run[%0d]", n), run_len[n], erun);
        end
        check("lat_while_oe", viol_lat_oe, 0);
        check("row_sel_outside_lat", viol_rowsel, 0);
        check("rgb_change_oclk_high", viol_rgb, 0);
        check("flip_ack_count", ack_cnt, 1);
        check("flip_ack_frame", ack_nlat, BD * ROWS);
        check("flip_ack_after_lat", ack_after_lat, 1);

        // Reset in the middle of a display period
        k = 0;
        while (!oe && k < 400) begin @(negedge clk); k++; end
        check("oe_before_reset", oe, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_oe", oe, 0);
        check("mid_rst_lat", lat, 0);
        check("mid_rst_oclk", oclk, 0);
        check("mid_rst_rgb", rgb, 0);
        check("mid_rst_row", row, 0);
        check("mid_rst_column", column, 0);
        lat_seen = 0;
        repeat (2) begin @(negedge clk); if (lat) lat_seen++; end
        check("lat_in_reset", lat_seen, 0);
`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
        brightness = 8'h00;
`endif
        rst = 1'b0;
        k = 0;
        while (!lat && k < 400) begin @(negedge clk); k++; end
        check("first_lat_delay", k, PL + 2 * COLS + BT + 1);
        check("first_lat_row_sel", row_sel, 0);

`ifdef DISPLAY_DRIVER_BRIGHTNESS_EN
        // Zero brightness: no lit clocks over a whole frame
        lat_seen = 0; oe_seen = 0; k = 0;
        while (lat_seen < BD * ROWS && k < 3000) begin
            @(negedge clk); k++;
            if (lat) lat_seen++;
            if (oe) oe_seen++;
        end
        check("dark_frame_lats", lat_seen, BD * ROWS);
        check("dark_frame_oe", oe_seen, 0);
`else
        oe_seen = 0;
`endif

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
